// File: rtl/mash_pkg.sv
// Shared constants, types and helpers for the MASH delta-sigma modulator.
package mash_pkg;

  localparam int          MAX_ORDER = 4;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10).
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  typedef logic [2:0] order_t;

  // Map the runtime order request onto what is actually built: 0 -> 1, above max -> max.
  function automatic order_t eff_order(input order_t cfg, input int max_order);
    if (cfg == 3'd0) return 3'd1;
    if (int'(cfg) > max_order) return order_t'(max_order);
    return cfg;
  endfunction

  // Tap j of (1 - z^-1)^n: (-1)^j * C(n, j).
  function automatic int dcoef(input int n, input int j);
    int c;
    c = 1;
    for (int i = 0; i < j; i++) c = c * (n - i) / (i + 1);
    return (j % 2 != 0) ? -c : c;
  endfunction

endpackage

// File: rtl/mash_n_dsm_if.sv
// AXI-Stream data channel used on both sides of the modulator.
interface mash_n_dsm_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mash_efm_stage.sv
// First-order error-feedback stage: acc + in + cin, carry out, wrap modulo 2^WIDTH.
module mash_efm_stage
  import mash_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             cin,
  input  logic [WIDTH-1:0] in,
  output logic             carry,
  output logic [WIDTH-1:0] err
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  // One bit wider than the accumulator so the overflow becomes the carry; a cleared stage emits nothing.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here unconditionally) so no latch is inferred.
    sum   = {1'b0, acc} + {1'b0, in} + {{WIDTH{1'b0}}, cin};
    carry = clr ? 1'b0 : sum[WIDTH];
    err   = clr ? '0 : sum[WIDTH-1:0];
  end

  // Accumulator takes the new error on accept and is held at zero while the stage is disabled.
  always_ff @(posedge aclk) begin
    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
    if (!arst_n || clr) acc <= '0;
    else if (en)        acc <= err;
  end

endmodule

// File: rtl/mash_n_dsm.sv
// Runtime-selectable-order MASH modulator with LFSR dither and AXIS backpressure.
module mash_n_dsm
  import mash_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ORDER  = 3,
  parameter int OUT_BW = 4
) (
  input  logic          aclk,
  input  logic          arst_n,
  mash_n_dsm_if.slave   s_axis_data,
  mash_n_dsm_if.master  m_axis_data,
  input  order_t        cfg_order,
  input  logic          cfg_dither
);

  if (ORDER < 1 || ORDER > MAX_ORDER) begin : g_bad_order
    $error("mash_n_dsm: ORDER must be 1..%0d", MAX_ORDER);
  end
  if (OUT_BW < ORDER + 1) begin : g_bad_bw
    $error("mash_n_dsm: OUT_BW must be at least ORDER+1");
  end

  logic                     s_ready;
  logic                     accept;
  order_t                   eff;
  logic [15:0]              lfsr;
  logic                     dither_bit;
  logic [ORDER-1:0]         stage_clr;
  logic [ORDER-1:0]         carry;
  logic [WIDTH-1:0]         err  [ORDER];
  logic signed [OUT_BW-1:0] term [ORDER];
  logic signed [OUT_BW-1:0] y_next;

  // Single output register, no skid: accept only when the output slot is free or draining.
  assign s_ready            = arst_n & (~m_axis_data.tvalid | m_axis_data.tready);
  assign s_axis_data.tready = s_ready;
  assign accept             = s_axis_data.tvalid & s_ready;
  assign eff                = eff_order(cfg_order, ORDER);
  assign dither_bit         = cfg_dither & lfsr[0];

  for (genvar s = 0; s < ORDER; s++) begin : g_stage
    logic [WIDTH-1:0]         stage_in;
    logic [s:0]               taps;
    logic signed [OUT_BW-1:0] term_l;

    assign stage_clr[s] = (order_t'(s) >= eff);

    if (s == 0) begin : g_first
      assign stage_in = s_axis_data.tdata;
    end else begin : g_chain
      assign stage_in = err[s-1];
    end

    mash_efm_stage #(.WIDTH(WIDTH)) u_stage (
      .aclk  (aclk),
      .arst_n(arst_n),
      .en    (accept),
      .clr   (stage_clr[s]),
      .cin   ((s == 0) ? dither_bit : 1'b0),
      .in    (stage_in),
      .carry (carry[s]),
      .err   (err[s])
    );

    // taps[j] is this stage's carry j accepted samples ago.
    if (s == 0) begin : g_nohist
      assign taps = carry[0];
    end else begin : g_hist
      logic [s-1:0] hist;
      assign taps = {hist, carry[s]};

      // Carry history shifts on accept only; a disabled stage restarts from an all-zero history.
      always_ff @(posedge aclk) begin
        // NOTE: the history is a few flops, so it is reset like any other state rather than left uninitialised.
        if (!arst_n || stage_clr[s]) hist <= '0;
        else if (accept)             hist <= taps[s-1:0];
      end
    end

    // Apply (1 - z^-1)^s to this stage's carry stream.
    always_comb begin
      term_l = '0;
      for (int j = 0; j <= s; j++) begin
        if (taps[j]) term_l = term_l + OUT_BW'(dcoef(s, j));
      end
    end

    assign term[s] = term_l;
  end

  // Recombine the differentiated carries; the range fits OUT_BW so plain wrap arithmetic is exact.
  always_comb begin
    y_next = '0;
    for (int s = 0; s < ORDER; s++) y_next = y_next + term[s];
  end

  // LFSR steps once per accepted sample regardless of whether dither is used.
  always_ff @(posedge aclk) begin
    if (!arst_n)     lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_POLY)};
  end

  // Output register: load on accept, drop valid after a handshake, hold while stalled.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      m_axis_data.tvalid <= 1'b0;
      m_axis_data.tdata  <= '0;
    end else if (accept) begin
      m_axis_data.tvalid <= 1'b1;
      m_axis_data.tdata  <= y_next;
    end else if (m_axis_data.tready) begin
      m_axis_data.tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mash_n_dsm.sv
// Directed bench for mash_n_dsm with a cycle reference model and hand-computed sequences.
module tb_mash_n_dsm;
  import mash_pkg::*;

  localparam int W   = 16;
  localparam int ORD = 3;
  localparam int OBW = 4;

  logic   aclk   = 1'b0;
  logic   arst_n = 1'b0;
  order_t cfg_order  = 3'd1;
  logic   cfg_dither = 1'b0;

  mash_n_dsm_if #(.DW(W))   s_if ();
  mash_n_dsm_if #(.DW(OBW)) m_if ();

  mash_n_dsm #(.WIDTH(W), .ORDER(ORD), .OUT_BW(OBW)) dut (
    .aclk       (aclk),
    .arst_n     (arst_n),
    .s_axis_data(s_if),
    .m_axis_data(m_if),
    .cfg_order  (cfg_order),
    .cfg_dither (cfg_dither)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // stimulus controls applied at the next drive point
  logic   rst_drv = 1'b0;
  order_t c_ord   = 3'd1;
  logic   c_dith  = 1'b0;

  // reference model state
  int unsigned acc_m [1:3];
  int          h2_1, h3_1, h3_2;
  logic [15:0] lfsr_m;
  logic        exp_v, exp_zero, exp_rdy;
  logic signed [OBW-1:0] exp_d;

  // observed output of the current cycle
  logic                  obs_v;
  logic signed [OBW-1:0] obs_y;
  int                    sum_y;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 1; k <= 3; k++) acc_m[k] = 0;
    h2_1 = 0; h3_1 = 0; h3_2 = 0;
    lfsr_m   = 16'h0001;
    exp_v    = 1'b0;
    exp_zero = 1'b1;
    exp_d    = '0;
  endfunction

  function automatic int model_step(input int unsigned x, input int ord, input bit dith);
    int eff, s, y;
    int unsigned e;
    int c [1:3];
    eff = (ord == 0) ? 1 : ((ord > ORD) ? ORD : ord);
    s = int'(acc_m[1] + x + ((dith && lfsr_m[0]) ? 1 : 0));
    c[1] = s / 65536;
    acc_m[1] = s % 65536;
    e = acc_m[1];
    for (int k = 2; k <= 3; k++) begin
      if (k <= eff) begin
        s = int'(acc_m[k] + e);
        c[k] = s / 65536;
        acc_m[k] = s % 65536;
        e = acc_m[k];
      end else begin
        acc_m[k] = 0;
        c[k] = 0;
        if (k == 2) h2_1 = 0;
        else begin h3_1 = 0; h3_2 = 0; end
      end
    end
    y = c[1] + (c[2] - h2_1) + (c[3] - 2 * h3_1 + h3_2);
    h2_1 = c[2];
    h3_2 = h3_1;
    h3_1 = c[3];
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    return y;
  endfunction

  // One clock: sample outputs, drive inputs, check ready, advance the model.
  task automatic cyc(input logic [W-1:0] x, input logic v, input logic mr);
    @(negedge aclk);
    obs_v = m_if.tvalid;
    obs_y = $signed(m_if.tdata);
    check("m_tvalid", {31'd0, m_if.tvalid}, {31'd0, exp_v});
    if (exp_v || exp_zero) check("m_tdata", obs_y, exp_d);
    arst_n      = rst_drv;
    cfg_order   = c_ord;
    cfg_dither  = c_dith;
    s_if.tdata  = x;
    s_if.tvalid = v;
    m_if.tready = mr;
    #1;
    exp_rdy = rst_drv & (~exp_v | mr);
    check("s_tready", {31'd0, s_if.tready}, {31'd0, exp_rdy});
    if (rst_drv && obs_v && mr) sum_y += int'(obs_y);
    if (!rst_drv) model_reset();
    else if (v && exp_rdy) begin
      exp_d    = OBW'(model_step(x, int'(c_ord), c_dith));
      exp_v    = 1'b1;
      exp_zero = 1'b0;
    end else if (mr) exp_v = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_drv = 1'b0;
    cyc('0, 1'b1, 1'b1);
    cyc('0, 1'b1, 1'b1);
    rst_drv = 1'b1;
  endtask

  // Continuous stream at constant x from a quiet output; compare against a hand table.
  task automatic run_table(input logic [W-1:0] x, input int tbl [4], input string tag);
    for (int i = 0; i < 9; i++) begin
      cyc(x, 1'b1, 1'b1);
      if (i == 0) check({tag, "_lat0"}, {31'd0, obs_v}, 0);
      else begin
        check({tag, "_valid"}, {31'd0, obs_v}, 1);
        check({tag, "_y"}, obs_y, tbl[(i - 1) % 4]);
      end
    end
  endtask

  int t1 [4] = '{0, 0, 0, 1};
  int t2 [4] = '{0, 1, 1, 0};

  initial begin
    model_reset();
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    @(posedge aclk);
    // reset state with s_tvalid asserted
    cyc('0, 1'b1, 1'b1);
    cyc('0, 1'b1, 1'b1);
    rst_drv = 1'b1;

    // 1: order 1, x = 0x4000
    c_ord = 3'd1;
    run_table(16'h4000, t1, "t1");

    // 2: order 2, x = 0x8000
    pulse_reset();
    c_ord = 3'd2;
    run_table(16'h8000, t2, "t2");

    // 5: mid-stream reset, then the order-1 sequence restarts from scratch
    c_ord = 3'd1;
    for (int i = 0; i < 6; i++) cyc(16'h4000, 1'b1, 1'b1);
    pulse_reset();
    run_table(16'h4000, t1, "t5");

    // 3: order 3, full-scale input, range and long-run mean
    pulse_reset();
    c_ord = 3'd3;
    sum_y = 0;
    for (int i = 0; i < 65536; i++) begin
      cyc(16'hFFFF, 1'b1, 1'b1);
      if (i > 0 && (obs_y < -3 || obs_y > 4)) check("t3_range", obs_y, 0);
    end
    cyc('0, 1'b0, 1'b1);
    check("t3_range_last", {31'd0, (obs_y >= -3 && obs_y <= 4)}, 1);
    check("t3_sum_dev", {31'd0, (sum_y >= 65531 && sum_y <= 65539)}, 1);

    // 4: order 3, random data and backpressure with a forced 10-cycle stall
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      logic v, mr;
      v  = (i == 99) ? 1'b1 : ($urandom_range(0, 3) != 0);
      mr = (i >= 100 && i < 110) ? 1'b0 : 1'(($urandom_range(0, 1)));
      cyc(W'($urandom), v, mr);
    end
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);

    // 6: dither on, x = 0, order 3 -> 1 -> 7(clamps to 3) -> 0(clamps to 1)
    pulse_reset();
    c_dith = 1'b1;
    c_ord  = 3'd3;
    for (int i = 0; i < 40; i++) cyc('0, 1'b1, 1'b1);
    c_ord = 3'd1;
    for (int i = 0; i < 60; i++) begin
      cyc('0, 1'b1, 1'b1);
      if (i > 0) check("t6_ord1_y", {31'd0, (obs_y == 0 || obs_y == 1)}, 1);
    end
    c_ord = 3'd7;
    for (int i = 0; i < 40; i++) cyc('0, 1'b1, 1'b1);
    c_ord = 3'd0;
    for (int i = 0; i < 20; i++) cyc('0, 1'b1, 1'b1);
    cyc('0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
